// File: rtl/arbitro_mux4.sv
// arbitro_mux4: round-robin arbiter sharing one registered ANCHO-bit output
// between four lanes, each with a one-entry valid/ready holding buffer.
// Ports: clk_4f, reset (sync, active-low), EntradaN/validEntradaN/listoEntradaN
// per lane; listoSalida in; Salida, validSalida, selector, lleno out.
// Option: define ARBITRO_IDLE_BC_EN to load 8'hBC into Salida when idle.
module arbitro_mux4 #(
  parameter int ANCHO = 8
) (
  input  logic             clk_4f,
  input  logic             reset,
  input  logic [ANCHO-1:0] Entrada0,
  input  logic [ANCHO-1:0] Entrada1,
  input  logic [ANCHO-1:0] Entrada2,
  input  logic [ANCHO-1:0] Entrada3,
  input  logic             validEntrada0,
  input  logic             validEntrada1,
  input  logic             validEntrada2,
  input  logic             validEntrada3,
  output logic             listoEntrada0,
  output logic             listoEntrada1,
  output logic             listoEntrada2,
  output logic             listoEntrada3,
  input  logic             listoSalida,
  output logic [ANCHO-1:0] Salida,
  output logic             validSalida,
  output logic [1:0]       selector,
  output logic [3:0]       lleno
);

  typedef enum logic {
    INACTIVO,
    ACTIVO
  } estado_t;

  estado_t          estado;
  estado_t          estado_n;
  logic [ANCHO-1:0] ent [4];
  logic [ANCHO-1:0] dato [4];
  logic [3:0]       valid_in;
  logic [3:0]       lleno_q;
  logic [3:0]       lleno_n;
  logic [1:0]       puntero;
  logic [1:0]       puntero_n;
  logic [ANCHO-1:0] salida_q;
  logic [ANCHO-1:0] salida_n;
  logic [1:0]       sel_q;
  logic [1:0]       sel_n;
  logic             avanza;
  logic             hay;
  logic [1:0]       g;
  logic [1:0]       idx;
  logic             gnt;

  assign ent[0] = Entrada0;
  assign ent[1] = Entrada1;
  assign ent[2] = Entrada2;
  assign ent[3] = Entrada3;

  assign valid_in = {validEntrada3, validEntrada2,
                     validEntrada1, validEntrada0};

  assign listoEntrada0 = ~lleno_q[0];
  assign listoEntrada1 = ~lleno_q[1];
  assign listoEntrada2 = ~lleno_q[2];
  assign listoEntrada3 = ~lleno_q[3];

  assign lleno       = lleno_q;
  assign Salida      = salida_q;
  assign selector    = sel_q;
  assign validSalida = (estado == ACTIVO);

  // first full lane at or after the pointer
  always_comb begin
    hay = 1'b0;
    g   = 2'd0;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = puntero + 2'(i);
      if (!hay && lleno_q[idx]) begin
        hay = 1'b1;
        g   = idx;
      end
    end
  end

  always_comb begin
    avanza    = (estado == INACTIVO) | listoSalida;
    estado_n  = estado;
    salida_n  = salida_q;
    sel_n     = sel_q;
    puntero_n = puntero;
    gnt       = 1'b0;
    if (avanza) begin
      if (hay) begin
        estado_n  = ACTIVO;
        salida_n  = dato[g];
        sel_n     = g;
        puntero_n = g + 2'd1;
        gnt       = 1'b1;
      end else begin
        estado_n = INACTIVO;
`ifdef ARBITRO_IDLE_BC_EN
        salida_n = ANCHO'(8'hBC);
        sel_n    = 2'd0;
`endif
      end
    end
  end

  // a granted lane is full, so capture and grant never hit the same lane
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (lleno_q[i])
        lleno_n[i] = ~(gnt && (g == 2'(i)));
      else
        lleno_n[i] = valid_in[i];
    end
  end

  always_ff @(posedge clk_4f) begin
    if (!reset) begin
      estado   <= INACTIVO;
      lleno_q  <= 4'b0000;
      puntero  <= 2'd0;
      salida_q <= '0;
      sel_q    <= 2'd0;
      for (int i = 0; i < 4; i++)
        dato[i] <= '0;
    end else begin
      estado   <= estado_n;
      lleno_q  <= lleno_n;
      puntero  <= puntero_n;
      salida_q <= salida_n;
      sel_q    <= sel_n;
      for (int i = 0; i < 4; i++)
        if (!lleno_q[i] && valid_in[i])
          dato[i] <= ent[i];
    end
  end

endmodule

// File: tb/tb_arbitro_mux4.sv
// tb_arbitro_mux4: directed bench for arbitro_mux4 with a lane/queue model
// checked every cycle plus literal expectations from the test plan.
module tb_arbitro_mux4;

  logic       clk_4f = 1'b0;
  logic       reset;
  logic [7:0] ent [4];
  logic [3:0] vin;
  logic [3:0] lst;
  logic       listoSalida;
  logic [7:0] Salida;
  logic       validSalida;
  logic [1:0] selector;
  logic [3:0] lleno;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_4f = ~clk_4f;

  arbitro_mux4 #(.ANCHO(8)) dut (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .Entrada0      (ent[0]),
    .Entrada1      (ent[1]),
    .Entrada2      (ent[2]),
    .Entrada3      (ent[3]),
    .validEntrada0 (vin[0]),
    .validEntrada1 (vin[1]),
    .validEntrada2 (vin[2]),
    .validEntrada3 (vin[3]),
    .listoEntrada0 (lst[0]),
    .listoEntrada1 (lst[1]),
    .listoEntrada2 (lst[2]),
    .listoEntrada3 (lst[3]),
    .listoSalida   (listoSalida),
    .Salida        (Salida),
    .validSalida   (validSalida),
    .selector      (selector),
    .lleno         (lleno)
  );

`ifdef ARBITRO_IDLE_BC_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  // model: per-lane slot, round-robin pointer, output register
  logic [3:0] m_full;
  logic [7:0] m_dat [4];
  int         m_ptr;
  logic [7:0] m_out;
  logic       m_vout;
  logic [1:0] m_sel;
  logic       armed = 1'b0;
  logic       m_adv;
  int         m_g;

  function automatic int find_grant(logic [3:0] f, int p);
    for (int k = 0; k < 4; k++)
      if (f[(p + k) % 4])
        return (p + k) % 4;
    return -1;
  endfunction

  always_comb begin
    m_adv = !m_vout || listoSalida;
    m_g   = -1;
    if (m_adv)
      m_g = find_grant(m_full, m_ptr);
  end

  always @(posedge clk_4f) begin
    armed <= 1'b1;
    if (!reset) begin
      m_full <= 4'b0000;
      m_ptr  <= 0;
      m_out  <= 8'h00;
      m_vout <= 1'b0;
      m_sel  <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_full[i]) begin
          m_full[i] <= (m_g != i);
        end else begin
          m_full[i] <= vin[i];
          if (vin[i])
            m_dat[i] <= ent[i];
        end
      end
      if (m_adv) begin
        if (m_g >= 0) begin
          m_out  <= m_dat[m_g];
          m_sel  <= 2'(m_g);
          m_vout <= 1'b1;
          m_ptr  <= (m_g + 1) % 4;
        end else begin
          m_vout <= 1'b0;
          if (BC) begin
            m_out <= 8'hBC;
            m_sel <= 2'd0;
          end
        end
      end
    end
  end

  always @(negedge clk_4f) begin
    if (armed) begin
      n_tests++;
      if (validSalida !== m_vout || Salida !== m_out
          || selector !== m_sel) begin
        n_fail++;
        $display("FAIL model_out: got v=%b d=%h s=%0d want v=%b d=%h s=%0d",
                 validSalida, Salida, selector, m_vout, m_out, m_sel);
      end
      n_tests++;
      if (lleno !== m_full || lst !== ~m_full) begin
        n_fail++;
        $display("FAIL model_lanes: got lleno=%b listo=%b want lleno=%b",
                 lleno, lst, m_full);
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #2;
  endtask

  task automatic outp(string nm, logic v, logic [7:0] d, logic [1:0] s);
    chk({nm, "_valid"}, 32'(validSalida), 32'(v));
    if (v) begin
      chk({nm, "_data"}, 32'(Salida), 32'(d));
      chk({nm, "_sel"}, 32'(selector), 32'(s));
    end
  endtask

  task automatic load(logic [3:0] m, logic [7:0] d0, logic [7:0] d1,
                      logic [7:0] d2, logic [7:0] d3);
    ent[0] = d0;
    ent[1] = d1;
    ent[2] = d2;
    ent[3] = d3;
    vin    = m;
    tick();
    vin = 4'b0000;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  logic [7:0] rr [4];
  logic [3:0] v_pat [12];
  logic       l_pat [12];

  initial begin
    reset       = 1'b0;
    vin         = 4'b1111;
    listoSalida = 1'b1;
    for (int i = 0; i < 4; i++)
      ent[i] = 8'hF0 + 8'(i);
    tick();
    tick();
    chk("rst_lleno", 32'(lleno), 32'h0);
    chk("rst_valid", 32'(validSalida), 32'h0);
    chk("rst_salida", 32'(Salida), 32'h0);
    chk("rst_sel", 32'(selector), 32'h0);
    chk("rst_listo", 32'(lst), 32'hF);

    reset = 1'b1;
    vin   = 4'b0000;
    load(4'b0100, 8'h00, 8'h00, 8'h5A, 8'h00);
    chk("single_lleno", 32'(lleno), 32'h4);
    chk("single_idle", 32'(validSalida), 32'h0);
    tick();
    outp("single", 1'b1, 8'h5A, 2'd2);
    chk("single_drain_lleno", 32'(lleno), 32'h0);
    tick();
    chk("single_after", 32'(validSalida), 32'h0);
    chk("single_after_lleno", 32'(lleno), 32'h0);

    do_reset();
    rr[0] = 8'h11;
    rr[1] = 8'h22;
    rr[2] = 8'h33;
    rr[3] = 8'h44;
    for (int r = 0; r < 2; r++) begin
      load(4'b1111, 8'h11, 8'h22, 8'h33, 8'h44);
      for (int i = 0; i < 4; i++) begin
        tick();
        outp("rr", 1'b1, rr[i], 2'(i));
      end
      tick();
      chk("rr_done", 32'(validSalida), 32'h0);
    end

    // drive pointer to 3 via a lone lane-2 grant
    load(4'b0100, 8'h00, 8'h00, 8'h77, 8'h00);
    tick();
    outp("wrap_pre", 1'b1, 8'h77, 2'd2);
    tick();
    load(4'b1010, 8'h00, 8'hA1, 8'h00, 8'hA3);
    tick();
    outp("wrap_first", 1'b1, 8'hA3, 2'd3);
    tick();
    outp("wrap_second", 1'b1, 8'hA1, 2'd1);
    tick();
    load(4'b0110, 8'h00, 8'hB1, 8'hB2, 8'h00);
    tick();
    outp("wrap_ptr2", 1'b1, 8'hB2, 2'd2);
    tick();
    outp("wrap_ptr3", 1'b1, 8'hB1, 2'd1);
    tick();

    do_reset();
    load(4'b1110, 8'h00, 8'h22, 8'h33, 8'h44);
    tick();
    outp("bp_first", 1'b1, 8'h22, 2'd1);
    listoSalida = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      outp("bp_hold", 1'b1, 8'h22, 2'd1);
      chk("bp_lleno", 32'(lleno), 32'hC);
    end
    listoSalida = 1'b1;
    tick();
    outp("bp_next", 1'b1, 8'h33, 2'd2);
    tick();
    outp("bp_last", 1'b1, 8'h44, 2'd3);
    tick();
    chk("idle_valid", 32'(validSalida), 32'h0);
    chk("idle_salida", 32'(Salida), BC ? 32'hBC : 32'h44);
    chk("idle_sel", 32'(selector), BC ? 32'h0 : 32'h3);

    load(4'b0111, 8'h55, 8'h66, 8'h77, 8'h00);
    tick();
    outp("mr_first", 1'b1, 8'h55, 2'd0);
    chk("mr_lleno", 32'(lleno), 32'h6);
    reset = 1'b0;
    tick();
    chk("mr_lleno0", 32'(lleno), 32'h0);
    chk("mr_valid0", 32'(validSalida), 32'h0);
    chk("mr_salida0", 32'(Salida), 32'h0);
    chk("mr_sel0", 32'(selector), 32'h0);
    reset = 1'b1;
    tick();
    tick();
    chk("mr_stale_valid", 32'(validSalida), 32'h0);
    chk("mr_stale_lleno", 32'(lleno), 32'h0);

    // streaming with concurrent capture, grant and backpressure
    v_pat = '{4'b0011, 4'b0011, 4'b1011, 4'b1111, 4'b0101, 4'b0000,
              4'b1000, 4'b1111, 4'b1111, 4'b0010, 4'b0000, 4'b0000};
    l_pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0,
              1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < 4; i++)
        ent[i] = 8'(i * 16 + c);
      vin         = v_pat[c];
      listoSalida = l_pat[c];
      tick();
    end
    vin         = 4'b0000;
    listoSalida = 1'b1;
    for (int c = 0; c < 8; c++)
      tick();
    chk("stream_drained", 32'(lleno), 32'h0);

    @(posedge clk_4f);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/arbitro_mux4.md
# arbitro_mux4

Round-robin scheduler that shares one byte-wide output lane between four byte-wide requesters. Each requester gets a one-entry holding buffer with a valid/ready handshake. The arbiter grants one buffered byte per cycle to a registered output stage, with downstream backpressure. It sits in front of the serializing mux path, running in the fastest clock domain, and also reports which lane is on the output.

## Interface
Parameters:
- ANCHO, 8, data width of every lane and of Salida.

Ports:
- clk_4f  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; sampled on clk_4f rising edge.
- Entrada0..Entrada3  in  ANCHO  requester data, one bus per lane.
- validEntrada0..validEntrada3  in  1  requester N presents a byte.
- listoEntrada0..listoEntrada3  out  1  lane N buffer can accept a byte.
- listoSalida  in  1  downstream accepts the current Salida.
- Salida  out  ANCHO  granted byte, registered.
- validSalida  out  1  Salida holds a valid byte.
- selector  out  2  lane index of the byte in Salida.
- lleno  out  4  bit N set means the lane N holding buffer is full.

## Operation
- Lane buffers:
  - Each lane N has `datoN[ANCHO]` and `llenoN`.
  - `listoEntradaN = ~llenoN`, combinational from state only.
  - Capture condition: `validEntradaN & listoEntradaN` at the edge. On capture, `datoN <= EntradaN` and `llenoN <= 1`.
  - `validEntradaN` while `llenoN=1` is ignored. The requester must hold its data.
- Output stage FSM, states INACTIVO and ACTIVO:
  - Define `avanza = ~validSalida | listoSalida`.
  - On `avanza`, the arbiter searches lanes `puntero, puntero+1, … puntero+3` (mod 4) for the first with `lleno=1`.
  - If a lane `g` is found:
    - `Salida <= dato_g`, `selector <= g`, `validSalida <= 1`.
    - `lleno_g <= 0`.
    - `puntero <= g+1` (mod 4, 2-bit wrap from 3 to 0).
    - Next state is ACTIVO.
  - If no lane is full: `validSalida <= 0` and the next state is INACTIVO. `Salida` and `selector` hold their values (see Configuration).
  - Without `avanza` (ACTIVO and `listoSalida=0`): `Salida`, `selector`, `validSalida` and `puntero` all hold. No buffer is cleared.
- Simultaneous events:
  - A granted lane is full that cycle, so it cannot also capture. It shows `listoEntrada=1` on the next cycle. Per-lane throughput is therefore 1 byte per 2 cycles.
  - Aggregate throughput reaches 1 byte per cycle when two or more lanes are loaded.
  - A capture on lane N and a grant of a different lane in the same cycle are independent.
  - A byte captured at edge k is eligible for grant at edge k+1, not at edge k.

## Timing
- Reset (`reset=0` at an edge), state after the edge:
  - `lleno = 4'b0000`, all `listoEntradaN = 1`.
  - `validSalida = 0`, `Salida = 0`, `selector = 0`.
  - `puntero = 0`, FSM in INACTIVO.
- Reset asserted mid-transfer discards every buffered byte and the byte on the output. No partial grant survives.
- Latency: `validEntradaN` high at edge k, `validSalida` with that byte at edge k+1 at the earliest, i.e. 2 edges from capture to the output register.
- Handshakes:
  - A byte transfers downstream at each edge where `validSalida & listoSalida`.
  - A `Salida` value is never changed while `validSalida=1 & listoSalida=0`.
- Fairness: with all four lanes continuously full, grants follow 0,1,2,3,0,… from reset. No lane waits more than 3 grants.

## Configuration
- `ARBITRO_IDLE_BC_EN`:
  - **Defined:** on any `avanza` edge with no lane full, `Salida <= 8'hBC` (idle comma, low 8 bits; upper bits 0 when ANCHO > 8) and `selector <= 0`. Reset value of `Salida` remains 0.
  - **Undefined:** `Salida` and `selector` hold their last values when `validSalida` drops.

## Test plan
- **Reset:** hold `reset=0` for 2 cycles with all valid inputs high → `lleno=0000`, `validSalida=0`, `Salida=00`, `selector=0`, all `listoEntrada=1`.
- **Single lane:** `Entrada2=8'h5A` valid for 1 cycle → `lleno=0100` next cycle, then `Salida=5A`, `selector=2`, `validSalida=1`. The cycle after, `validSalida=0` and `lleno=0000`.
- **Round-robin:** load lanes 0..3 with `11,22,33,44` in the same cycle, `listoSalida=1` → Salida sequence 11,22,33,44 on consecutive cycles, selector 0,1,2,3. Reload all four → the order repeats starting at lane 0.
- **Pointer wrap:** `puntero` at 3, lanes 1 and 3 full → lane 3 granted first, then lane 1, and `puntero` ends at 2.
- **Backpressure:** `listoSalida=0` for 3 cycles while Salida=22 with lanes 2 and 3 full → Salida holds 22, `lleno` unchanged. On `listoSalida=1`, the next value is 33.
- **Idle fill and mid-reset:**
  - With `ARBITRO_IDLE_BC_EN`, after the last grant drains → `Salida=BC`, `validSalida=0`.
  - Asserting `reset` with 3 lanes full → everything is cleared on the next edge, and no stale byte appears after reset releases.
